// File: rtl/seven_segment_monitor_pkg.sv
// seven_segment_monitor shared constants: segment patterns,
// monitor states and period counter width.
package seven_segment_monitor_pkg;

  localparam int PCNT_W = 24;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK,
    LOCKED
  } mon_state_e;

endpackage

// File: rtl/seven_segment_monitor_decode.sv
// seg7_decode: segment pattern back to a decimal digit,
// flagging blank and unrecognised patterns.
module seg7_decode
  import seven_segment_monitor_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid,
  output logic       blank
);

  // one-hot match against the known glyphs
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    blank = 1'b0;
    unique case (1'b1)
      (pattern == SEG_0):     digit = 4'd0;
      (pattern == SEG_1):     digit = 4'd1;
      (pattern == SEG_2):     digit = 4'd2;
      (pattern == SEG_3):     digit = 4'd3;
      (pattern == SEG_4):     digit = 4'd4;
      (pattern == SEG_5):     digit = 4'd5;
      (pattern == SEG_6):     digit = 4'd6;
      (pattern == SEG_7):     digit = 4'd7;
      (pattern == SEG_8):     digit = 4'd8;
      (pattern == SEG_9):     digit = 4'd9;
      (pattern == SEG_BLANK): begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:                valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: debounced seven-segment stream checker.
// MONITOR_ACTIVE_LOW_EN selects common-anode (active-low) segments.
module seven_segment_monitor
  import seven_segment_monitor_pkg::*;
#(
  parameter int PERIOD        = 10_000_001,
  parameter int TOLERANCE     = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] STABLE =
    4'(STABLE_CYCLES);
  localparam logic [PCNT_W:0] P_LO =
    (PCNT_W+1)'(PERIOD - TOLERANCE);
  localparam logic [PCNT_W:0] P_HI =
    (PCNT_W+1)'(PERIOD + TOLERANCE);

  logic [7:0] sync1, sync2;
  logic [6:0] seg, prev_seg, last_pat;
  logic [3:0] stab_cnt, stab_nxt;
  logic       clr, accept;
  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W:0]   ivl;
  mon_state_e state, state_n;
  logic [3:0] digit, nxt_dig;
  logic [3:0] dec_digit;
  logic       dec_valid, dec_blank, dec_inv;
  logic       seq_ok, per_ok;
  logic       e_seq, e_per, e_inv;
  logic [1:0] inc;
  logic [8:0] cnt_sum;
  logic       seq_err, per_err, inv_err;
  logic [7:0] err_cnt;
  logic       unused;

  assign unused = ena ^ (^uio_in);

  // two-flop synchronizer on all inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
    end
  end

`ifdef MONITOR_ACTIVE_LOW_EN
  assign seg = ~sync2[6:0];
`else
  assign seg = sync2[6:0];
`endif
  assign clr = sync2[7];

  // run length of the current synced pattern
  always_comb begin
    stab_nxt = stab_cnt;
    if (seg != prev_seg)
      stab_nxt = 4'd1;
    else if (stab_cnt != STABLE)
      stab_nxt = stab_cnt + 4'd1;
  end

  assign accept = (stab_nxt == STABLE)
               && ((seg != prev_seg)
                   || (stab_cnt != STABLE))
               && (seg != last_pat);

  // debounce filter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_seg <= 7'h00;
      stab_cnt <= 4'd0;
      last_pat <= 7'h00;
    end else begin
      prev_seg <= seg;
      stab_cnt <= stab_nxt;
      if (accept) last_pat <= seg;
    end
  end

  seg7_decode u_dec (
    .pattern (seg),
    .digit   (dec_digit),
    .valid   (dec_valid),
    .blank   (dec_blank)
  );

  assign dec_inv = !dec_valid && !dec_blank;
  assign ivl     = {1'b0, pcnt} + 1'b1;
  assign per_ok  = (ivl >= P_LO) && (ivl <= P_HI);
  assign nxt_dig = (digit == 4'd9) ? 4'd0
                                   : digit + 4'd1;
  assign seq_ok  = (dec_digit == nxt_dig);

  // next state and error events on acceptance
  always_comb begin
    state_n = state;
    e_seq   = 1'b0;
    e_per   = 1'b0;
    e_inv   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        dec_blank: state_n = IDLE;
        dec_inv: begin
          state_n = IDLE;
          e_inv   = 1'b1;
        end
        default: begin
          unique case (state)
            IDLE: state_n = FIRST;
            FIRST: begin
              state_n = TRACK;
              e_seq   = !seq_ok;
            end
            default: begin
              e_seq   = !seq_ok;
              e_per   = !per_ok;
              state_n = (seq_ok && per_ok) ? LOCKED
                                           : TRACK;
            end
          endcase
        end
      endcase
    end
  end

  assign inc = {1'b0, e_seq} + {1'b0, e_per}
             + {1'b0, e_inv};
  assign cnt_sum = {1'b0, err_cnt} + {7'd0, inc};

  // interval counter, state and displayed digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt  <= '0;
      state <= IDLE;
      digit <= 4'd0;
    end else begin
      if (accept)
        pcnt <= '0;
      else if (pcnt != '1)
        pcnt <= pcnt + 1'b1;
      state <= state_n;
      if (accept && dec_valid) digit <= dec_digit;
    end
  end

  // sticky flags and saturating error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      per_err <= 1'b0;
      inv_err <= 1'b0;
      err_cnt <= 8'h00;
    end else if (clr) begin
      seq_err <= e_seq;
      per_err <= e_per;
      inv_err <= e_inv;
      err_cnt <= {6'd0, inc};
    end else begin
      seq_err <= seq_err | e_seq;
      per_err <= per_err | e_per;
      inv_err <= inv_err | e_inv;
      err_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  assign uo_out  = {inv_err, per_err, seq_err,
                    state == LOCKED, digit};
  assign uio_out = err_cnt;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb_seven_segment_monitor: random and directed digit streams
// checked against a behavioural model of the monitor.
module tb_seven_segment_monitor;

  localparam int P = 20;
  localparam int T = 2;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B,
    7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
    7'h6F};
  logic [6:0] BAD [4] = '{7'h49, 7'h12, 7'h01,
    7'h7E};

  logic [7:0] hist [$];
  int k = 0;
  int m_last_k, m_digit, m_cnt, m_st;
  logic [6:0] m_last_pat;
  bit m_seq, m_per, m_inv;

  seven_segment_monitor #(
    .PERIOD        (P),
    .TOLERANCE     (T),
    .STABLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  // 0..9 digit, 10 blank, -1 invalid
  function automatic int dec(input logic [6:0] p);
    if (p == 7'h00) return 10;
    for (int i = 0; i < 10; i++)
      if (PAT[i] == p) return i;
    return -1;
  endfunction

  task automatic model_step();
    int n, iv, d, inc;
    logic [6:0] s;
    bit cl, acc, es, ep, ei, sq, pk;
    k++;
    if (!rst_n) begin
      hist = {};
      repeat (8) hist.push_back(8'h00);
      m_last_k = k; m_digit = 0; m_cnt = 0;
      m_st = 0; m_last_pat = 7'h00;
      m_seq = 0; m_per = 0; m_inv = 0;
      return;
    end
    hist.push_back(ui_in);
    if (hist.size() > 16) void'(hist.pop_front());
    n  = hist.size();
    s  = hist[n-3][6:0];
    cl = hist[n-3][7];
    acc = (s != m_last_pat)
       && (s != hist[n-3-S][6:0]);
    for (int j = 1; j < S; j++)
      if (hist[n-3-j][6:0] != s) acc = 0;
    es = 0; ep = 0; ei = 0;
    if (acc) begin
      iv = k - m_last_k;
      if (iv > 2**24) iv = 2**24;
      d = dec(s);
      if (d == 10) m_st = 0;
      else if (d < 0) begin
        m_st = 0;
        ei = 1;
      end else begin
        sq = (d == (m_digit + 1) % 10);
        pk = (iv >= P - T) && (iv <= P + T);
        if (m_st == 0) m_st = 1;
        else if (m_st == 1) begin
          es = !sq;
          m_st = 2;
        end else begin
          es = !sq;
          ep = !pk;
          m_st = (sq && pk) ? 3 : 2;
        end
        m_digit = d;
      end
      m_last_k = k;
      m_last_pat = s;
    end
    inc = int'(es) + int'(ep) + int'(ei);
    if (cl) begin
      m_seq = es; m_per = ep; m_inv = ei;
      m_cnt = inc;
    end else begin
      m_seq |= es; m_per |= ep; m_inv |= ei;
      m_cnt = (m_cnt + inc > 255) ? 255
                                  : m_cnt + inc;
    end
  endtask

  task automatic tick();
    logic [7:0] exp_uo;
    @(posedge clk);
    model_step();
    #1;
    exp_uo = {m_inv, m_per, m_seq, m_st == 3,
              4'(m_digit)};
    chk("uo_out", 32'(uo_out), 32'(exp_uo));
    chk("uio_out", 32'(uio_out), 32'(m_cnt));
  endtask

  task automatic hold(input logic [6:0] p,
                      input int cyc);
    for (int i = 0; i < cyc; i++) begin
      ui_in = {1'b0, p};
      tick();
    end
  endtask

  task automatic clr_pulse(input logic [6:0] p);
    ui_in = {1'b1, p};
    tick();
  endtask

  initial begin
    int d0, dl, cur, r, hl, g;
    logic [6:0] np;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h7F;
    tick();
    chk("rst_uo", 32'(uo_out), 32'h0);
    chk("rst_uio", 32'(uio_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_uo", 32'(uo_out), 32'h0);
    chk("rel_uio", 32'(uio_out), 32'h0);
    chk("oe", 32'(uio_oe), 32'hFF);
    hold(7'h00, 6);

    d0 = $urandom_range(0, 9);
    for (int i = 0; i < 12; i++) begin
      cur = (d0 + i) % 10;
      hold(PAT[cur], 4);
      if (i > 0)
        chk("lat4", 32'(uo_out[3:0]),
            32'((cur + 9) % 10));
      hold(PAT[cur], 1);
      chk("lat5", 32'(uo_out[3:0]), 32'(cur));
      hold(PAT[cur], 15);
      if (i == 2)
        chk("lock3", 32'(uo_out[4]), 32'h1);
    end
    chk("clean_cnt", 32'(uio_out), 32'h0);
    chk("clean_lock", 32'(uo_out[4]), 32'h1);
    dl = (d0 + 11) % 10;

    hold(PAT[(dl + 2) % 10], 20);
    chk("seq_flag", 32'(uo_out[5]), 32'h1);
    chk("seq_lock", 32'(uo_out[4]), 32'h0);
    chk("seq_cnt", 32'(uio_out), 32'h1);
    hold(PAT[(dl + 3) % 10], 20);
    chk("seq_relock", 32'(uo_out[4]), 32'h1);
    hold(PAT[(dl + 3) % 10], 5);
    hold(PAT[(dl + 4) % 10], 18);
    chk("per_flag", 32'(uo_out[6]), 32'h1);
    chk("per_lock", 32'(uo_out[4]), 32'h0);
    chk("per_cnt", 32'(uio_out), 32'h2);
    hold(PAT[(dl + 5) % 10], 20);
    chk("per18_lock", 32'(uo_out[4]), 32'h1);

    hold(PAT[(dl + 6) % 10], 8);
    hold(7'h00, 2);
    hold(PAT[(dl + 6) % 10], 10);
    chk("glitch_lock", 32'(uo_out[4]), 32'h1);
    chk("glitch_dig", 32'(uo_out[3:0]),
        32'((dl + 6) % 10));
    hold(7'h49, 20);
    chk("inv_flag", 32'(uo_out[7]), 32'h1);
    chk("inv_lock", 32'(uo_out[4]), 32'h0);
    chk("inv_cnt", 32'(uio_out), 32'h3);
    chk("inv_dig", 32'(uo_out[3:0]),
        32'((dl + 6) % 10));

    clr_pulse(7'h49);
    hold(7'h49, 2);
    chk("clr_flags", 32'(uo_out[7:5]), 32'h0);
    chk("clr_cnt", 32'(uio_out), 32'h0);
    hold(PAT[0], 20);
    hold(7'h12, 2);
    clr_pulse(7'h12);
    hold(7'h12, 17);
    chk("clrinv_flag", 32'(uo_out[7]), 32'h1);
    chk("clrinv_cnt", 32'(uio_out), 32'h1);

    cur = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        cur = (cur + 1) % 10;
        np = PAT[cur];
      end else if (r < 80) begin
        cur = $urandom_range(0, 9);
        np = PAT[cur];
      end else if (r < 87) np = 7'h00;
      else if (r < 94) np = BAD[$urandom_range(0, 3)];
      else np = PAT[cur];
      hl = $urandom_range(15, 25);
      g  = $urandom_range(0, 9);
      if (g == 0) begin
        hold(np, 6);
        hold(7'($urandom), $urandom_range(1, 2));
        hold(np, hl - 6);
      end else if (g == 1) begin
        hold(np, 3);
        clr_pulse(np);
        hold(np, hl - 4);
      end else begin
        hold(np, hl);
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
